// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - configuration bus between a controller and clk_div_multi
//
// Signals:
//   cfg_wr      configuration write strobe
//   cfg_ch      target channel index
//   cfg_div     new divisor (0 behaves as 1)
//   cfg_mode    new mode (0 = square wave, 1 = tick)
//   cfg_pending per-channel flag: a shadow value is waiting for terminal count
// Modports: master drives the write fields and observes cfg_pending;
//           slave (the divider) receives the write fields and drives cfg_pending.

interface clk_div_multi_if #(
    parameter int CH = 4,
    parameter int DW = 16
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          cfg_wr;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_div;
    logic          cfg_mode;
    logic [CH-1:0] cfg_pending;

    modport master (
        output cfg_wr,
        output cfg_ch,
        output cfg_div,
        output cfg_mode,
        input  cfg_pending
    );

    modport slave (
        input  cfg_wr,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_mode,
        output cfg_pending
    );
endinterface

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock-enable generator
//
// Ports:
//   clk      master clock
//   rst      asynchronous, active-high reset
//   ch_en    per-channel run enable
//   sync     one-cycle strobe that realigns the phase of every channel
//   cfg      configuration bus (clk_div_multi_if.slave)
//   clk_out  per-channel registered square wave (period 2*D, 50% duty)
//   tick     per-channel registered one-cycle pulse every D cycles

module clk_div_multi #(
    parameter int CH           = 4,
    parameter int DW           = 16,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        ch_en,
    input  logic                 sync,
    clk_div_multi_if.slave       cfg,
    output logic [CH-1:0]        clk_out,
    output logic [CH-1:0]        tick
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [DW-1:0] cnt;
        logic [DW-1:0] act_div;
        logic [DW-1:0] sh_div;
        logic          act_mode;
        logic          sh_mode;
        logic          pending;
        logic          clk_q;
        logic          tick_q;

        logic          wr_hit;
        logic [DW-1:0] d_eff;
        logic          tc;
        logic          apply;
        logic          mode_chg;

        // Out-of-range channel indices never match any g, so such writes vanish.
        assign wr_hit   = cfg.cfg_wr && (cfg.cfg_ch == CW'(g));
        assign d_eff    = (act_div == '0) ? DW'(1) : act_div;
        // >= rather than == keeps the counter self-healing should cnt ever exceed D-1.
        assign tc       = (cnt >= (d_eff - DW'(1)));
        // A pending shadow is applied at a terminal count, or at once while disabled;
        // sync suppresses the apply so the realigned period still uses the old divisor.
        assign apply    = pending && !sync && (!ch_en[g] || tc);
        assign mode_chg = apply && (sh_mode != act_mode);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                act_div  <= DW'(DEFAULT_DIV);
                sh_div   <= DW'(DEFAULT_DIV);
                act_mode <= 1'(DEFAULT_MODE);
                sh_mode  <= 1'(DEFAULT_MODE);
                pending  <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                // The apply reads the old shadow, so a write landing on the same edge
                // is kept for the next period and pending stays set.
                if (apply) begin
                    act_div  <= sh_div;
                    act_mode <= sh_mode;
                end
                if (wr_hit) begin
                    sh_div  <= cfg.cfg_div;
                    sh_mode <= cfg.cfg_mode;
                    pending <= 1'b1;
                end else if (apply) begin
                    pending <= 1'b0;
                end

                if (sync || !ch_en[g]) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (tc) begin
                    cnt <= '0;
                    if (mode_chg) begin
                        clk_q  <= 1'b0;
                        tick_q <= 1'b0;
                    end else if (!act_mode) begin
                        clk_q  <= ~clk_q;
                        tick_q <= 1'b0;
                    end else begin
                        clk_q  <= 1'b0;
                        tick_q <= 1'b1;
                    end
                end else begin
                    cnt    <= cnt + DW'(1);
                    tick_q <= 1'b0;
                end
            end
        end

        assign clk_out[g]         = clk_q;
        assign tick[g]            = tick_q;
        assign cfg.cfg_pending[g] = pending;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi

module tb_clk_div_multi;
    localparam int CH = 5;
    localparam int DW = 16;
    localparam int CW = 3;

    typedef struct packed {
        logic [CH-1:0] co;
        logic [CH-1:0] tk;
        logic [CH-1:0] pd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] ch_en = '0;
    logic          sync = 1'b0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    clk_div_multi_if #(.CH(CH), .DW(DW)) cfg_if ();

    clk_div_multi #(.CH(CH), .DW(DW), .DEFAULT_DIV(2), .DEFAULT_MODE(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync    (sync),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    // Reference model: each channel is a sequence of "segments" with a fixed
    // divisor; n counts enabled edges since the segment started and base is the
    // square-wave level at the segment start.
    int m_n[CH], m_base[CH], m_div[CH], m_mode[CH];
    int m_shdiv[CH], m_shmode[CH], m_pend[CH];
    logic [CH-1:0] m_co, m_tk;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_n[c] = 0; m_base[c] = 0; m_div[c] = 2; m_mode[c] = 0;
            m_shdiv[c] = 2; m_shmode[c] = 0; m_pend[c] = 0;
        end
        m_co = '0;
        m_tk = '0;
    endfunction

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            int  d;
            bit  tc;
            bit  pend_old;
            bit  wr;
            pend_old = (m_pend[c] != 0);
            wr = cfg_if.cfg_wr && (int'(cfg_if.cfg_ch) == c);
            if (sync) begin
                m_n[c] = 0; m_base[c] = 0; m_co[c] = 0; m_tk[c] = 0;
            end else if (!ch_en[c]) begin
                m_n[c] = 0; m_base[c] = 0; m_co[c] = 0; m_tk[c] = 0;
                if (pend_old) begin
                    m_div[c] = m_shdiv[c]; m_mode[c] = m_shmode[c]; m_pend[c] = 0;
                end
            end else begin
                d = (m_div[c] == 0) ? 1 : m_div[c];
                m_n[c] = m_n[c] + 1;
                tc = (m_n[c] % d) == 0;
                if (m_mode[c] == 0) begin
                    m_co[c] = 1'(m_base[c] ^ ((m_n[c] / d) % 2));
                    m_tk[c] = 0;
                end else begin
                    m_co[c] = 0;
                    m_tk[c] = tc;
                end
                if (tc && pend_old) begin
                    if (m_shmode[c] != m_mode[c]) begin
                        m_co[c] = 0; m_tk[c] = 0;
                    end
                    m_div[c] = m_shdiv[c]; m_mode[c] = m_shmode[c]; m_pend[c] = 0;
                    m_n[c] = 0; m_base[c] = int'(m_co[c]);
                end
            end
            if (wr) begin
                m_shdiv[c] = int'(cfg_if.cfg_div); m_shmode[c] = int'(cfg_if.cfg_mode); m_pend[c] = 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.co = m_co;
        e.tk = m_tk;
        for (int c = 0; c < CH; c++) e.pd[c] = (m_pend[c] != 0);
        return e;
    endfunction

    // One clock edge: the model sees exactly the inputs the DUT samples, then
    // inputs may change 2 time units later.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        exp_q.push_back(model_out());
        cyc++;
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_cfg(input int ch, input int div, input int mode);
        cfg_if.cfg_wr = 1'b1;
        cfg_if.cfg_ch = CW'(ch);
        cfg_if.cfg_div = DW'(div);
        cfg_if.cfg_mode = 1'(mode);
        cycle();
        cfg_if.cfg_wr = 1'b0;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (clk_out !== '0 || tick !== '0 || cfg_if.cfg_pending !== '0) begin
            miscompares++;
            $display("FAIL async_rst: clk_out=%b tick=%b pend=%b expected all 0",
                     clk_out, tick, cfg_if.cfg_pending);
        end
        cycle();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: every sampled edge is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (clk_out !== e.co || tick !== e.tk || cfg_if.cfg_pending !== e.pd) begin
                    miscompares++;
                    $display("FAIL edge_%0d: clk_out=%b tick=%b pend=%b expected clk_out=%b tick=%b pend=%b",
                             cyc, clk_out, tick, cfg_if.cfg_pending, e.co, e.tk, e.pd);
                end
            end
        end
    end

    initial begin
        int p1[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        int divs[4] = '{2, 3, 4, 7};

        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0;
        cfg_if.cfg_mode = 1'b0;
        model_reset();
        run(3);
        rst = 1'b0;
        run(2);

        // Default channel 0: divide by 2, square wave
        ch_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk($sformatf("t1_clk0_e%0d", k), int'(clk_out[0]), p1[k]);
            chk($sformatf("t1_tick0_e%0d", k), int'(tick[0]), 0);
        end

        // Channel 1: configure while disabled, then enable
        write_cfg(1, 5, 1);
        chk("t2_pend_set", int'(cfg_if.cfg_pending[1]), 1);
        cycle();
        chk("t2_pend_clr", int'(cfg_if.cfg_pending[1]), 0);
        ch_en[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk($sformatf("t2_tick1_e%0d", k), int'(tick[1]), (k == 4 || k == 9) ? 1 : 0);
        end

        // Channel 0 divisor change mid-period
        cycle();
        write_cfg(0, 3, 0);
        run(14);

        // Out-of-range channel write, then div=0 in tick mode
        write_cfg(CH, 1, 1);
        run(3);
        write_cfg(2, 0, 1);
        ch_en[2] = 1'b1;
        run(10);

        // All channels running in square-wave mode, then a sync pulse
        for (int c = 0; c < 4; c++) write_cfg(c, divs[c], 0);
        ch_en = '1;
        run(30);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        run(20);

        // Reset mid-period with a pending write
        write_cfg(3, 5, 1);
        pulse_rst();
        run(12);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, CH - 1)] ^= 1'b1;
            sync = ($urandom_range(0, 49) == 0);
            cfg_if.cfg_wr = ($urandom_range(0, 5) == 0);
            cfg_if.cfg_ch = CW'($urandom_range(0, 7));
            cfg_if.cfg_div = DW'($urandom_range(0, 7));
            cfg_if.cfg_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) pulse_rst();
            else cycle();
        end
        sync = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        run(2);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock-enable generator; the parametrised successor to the fixed divide-by-4 pixel-clock divider. It derives up to CH independent rates from the 100 MHz master clock, such as the 25 MHz VGA pixel rate, sensor sample ticks and game-logic ticks. Each channel has a runtime-loadable divisor, a selectable square-wave or single-cycle-tick output, glitch-free divisor updates and a global phase-align strobe. It sits between the board clock input and every rate-dependent block.

## Interface
- CH, 4, number of channels (1..16)
- DW, 16, divisor width in bits
- DEFAULT_DIV, 2, divisor of every channel after reset (gives 25 MHz square wave from 100 MHz)
- DEFAULT_MODE, 0, mode after reset (0 = square wave, 1 = tick)
- clk  in  1  master clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- ch_en  in  CH  per-channel run enable
- sync  in  1  one-cycle strobe; realigns the phase of all channels
- cfg_wr  in  1  configuration write strobe
- cfg_ch  in  CW  target channel; CW = max(1, clog2(CH))
- cfg_div  in  DW  new divisor; 0 is treated as 1
- cfg_mode  in  1  new mode
- clk_out  out  CH  square-wave outputs, registered
- tick  out  CH  one-cycle pulse outputs, registered
- cfg_pending  out  CH  shadow value waiting for terminal count

## Operation
- Per-channel state: cnt[DW], act_div, act_mode, sh_div, sh_mode, pending, clk_out, tick.
- Reset values:
  - cnt = 0, act_div = sh_div = DEFAULT_DIV, act_mode = sh_mode = DEFAULT_MODE.
  - pending = 0, clk_out = 0, tick = 0.
- Priority per channel, evaluated on each rising edge: rst > sync > ch_en low > normal count.
- Normal count, ch_en high. Let D = act_div, or 1 if act_div = 0.
  - If cnt == D-1: cnt <= 0.
    - Mode 0: clk_out <= ~clk_out.
    - Mode 1: tick <= 1.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- Mode 0 holds tick at 0. Mode 1 holds clk_out at 0.
- Config write: a cfg_wr with cfg_ch < CH sets sh_div/sh_mode of that channel and sets pending. A write with cfg_ch >= CH is ignored entirely.
- Update timing: at a terminal-count edge where pending was already 1, act <= sh and pending <= 0. The new values govern the next period. The current period is never truncated, so no runt pulses.
- Write coinciding with terminal count:
  - If pending was already 1, the old shadow is loaded into act.
  - The new write lands in the shadow and pending stays 1.
- Back-to-back writes to a pending channel overwrite the shadow; the last write wins.
- Disabled channel (ch_en low):
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - A pending shadow is applied immediately, at the same edge.
- sync high: every channel gets cnt <= 0, clk_out <= 0, tick <= 0. Pending is not applied and shadow writes are still accepted.
- Mode switch: when the switch takes effect, clk_out and tick are forced to 0, then counting proceeds in the new mode.

## Timing
- Edge 0 is the first edge with ch_en sampled high, starting from cnt = 0.
  - Mode 1: first tick is high after edge D-1 and lasts exactly one cycle. Tick period is D cycles.
  - Mode 0: first clk_out rise is after edge D-1. Period is 2D cycles with exactly 50% duty.
- D = 1 edge cases:
  - Mode 1: tick stays continuously high.
  - Mode 0: clk_out = clk/2.
- Config-to-effect latency: from 1 cycle up to D_old cycles after the write edge.
- All outputs change only on the clk rising edge or on rst. No combinational path from any input to any output.
- rst asserted mid-period: outputs drop to reset values immediately. Counting restarts on the first enabled edge after deassertion.

## Test plan
- Reset, then ch_en[0]=1 with default settings -> clk_out[0] gives period 4 cycles, high 2, first rise after edge 1; tick[0] stays 0.
- Channel 1: write div=5, mode=1 while disabled, then enable -> cfg_pending[1] clears the next cycle; tick[1] pulses one cycle every 5 cycles, first after edge 4.
- Channel 0 running div=2, mode 0: write div=3 mid-period -> the current half-period completes at 2 cycles, then half-periods are 3; no runt pulse; pending clears at that terminal edge.
- Write with cfg_ch=CH, and write div=0 -> the first is ignored with no state change; div=0 behaves as div=1 (continuous tick in mode 1).
- All channels running at divs 2, 3, 4, 7, then pulse sync -> all clk_out/tick go to 0 together; with mode-0 divs 2, 3, 4, 7, the first rises are 2, 3, 4, 7 cycles after sync.
- Assert rst for 1 cycle mid-period and during a pending write -> all outputs are 0 and pending is 0; act_div returns to DEFAULT_DIV.
